memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 16 +
 rtl/memory_stage_dmem_req_fsm.sv | 117 +++++++++++
 rtl/memory_stage.sv | 112 +++++++++++
 tb/tb_memory_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM stage: request FSM state encodings, the default
// data-memory timeout and a word-alignment helper.
package memory_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } dmem_state_e;

    localparam int unsigned DMEM_TIMEOUT_DEF = 255;

    function automatic logic word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/memory_stage_dmem_req_fsm.sv
// Data-memory request sequencer: holds the request registers, tracks the
// IDLE/WAIT handshake and abandons an access after DMEM_TIMEOUT unacked cycles.
module dmem_req_fsm
    import memory_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mem_op,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_ack,
    output logic        o_req,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_err,
    output logic        o_misaligned
);

    localparam int CNT_W = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DMEM_TIMEOUT - 1);

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             misaligned_q, misaligned_d;
    logic             stall;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = 1'b0;
        misaligned_d = 1'b0;
        stall        = 1'b0;
        o_done       = 1'b0;
        o_pass       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An ack seen here belongs to an abandoned access and is dropped.
                if (!i_mem_op) begin
                    o_pass = 1'b1;
                end else if (word_aligned(i_addr[1:0])) begin
                    stall   = 1'b1;
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    we_d    = i_we;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                end else begin
                    misaligned_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_ack) begin
                    o_done  = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Last allowed cycle: release the pipe and let a bubble through.
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            misaligned_q <= misaligned_d;
        end
    end

    // The stall path is combinational from the EX/MEM inputs, so mask it during reset.
    assign o_stall      = stall & ~reset;
    assign o_req        = req_q;
    assign o_we         = we_q;
    assign o_addr       = addr_q;
    assign o_wdata      = wdata_q;
    assign o_err        = err_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: branch resolution, data-memory access through dmem_req_fsm,
// and the MEM/WB pipeline register.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = DMEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pipe_TargetAddr,
    input  logic [31:0] i_pipe_AluResult,
    input  logic        i_pipe_Zero,
    input  logic [31:0] i_pipe_Reg2Data,
    input  logic [4:0]  i_pipe_RegDst,
    input  logic        i_pipe_MemToReg,
    input  logic        i_pipe_RegWrEn,
    input  logic        i_pipe_MemWrEn,
    input  logic        i_pipe_Branch,
    input  logic        i_pipe_Jump,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_pipe_stall,
    output logic        o_PCSrc,
    output logic [31:0] o_TargetAddr,
    output logic [31:0] o_pipe_MemData,
    output logic [31:0] o_pipe_AluResult,
    output logic [4:0]  o_pipe_RegDst,
    output logic        o_pipe_MemToReg,
    output logic        o_pipe_RegWrEn,
    output logic        o_dmem_err,
    output logic        o_misaligned
);

    logic        mem_op;
    logic        fsm_done;
    logic        fsm_pass;

    logic [31:0] mem_data_q, mem_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  reg_dst_q, reg_dst_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic        reg_wr_en_q, reg_wr_en_d;

    assign mem_op       = i_pipe_MemToReg | i_pipe_MemWrEn;
    assign o_PCSrc      = i_pipe_Jump | (i_pipe_Branch & i_pipe_Zero);
    assign o_TargetAddr = i_pipe_TargetAddr;

    dmem_req_fsm #(
        .DMEM_TIMEOUT(DMEM_TIMEOUT)
    ) u_dmem_req_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_mem_op    (mem_op),
        .i_we        (i_pipe_MemWrEn),
        .i_addr      (i_pipe_AluResult),
        .i_wdata     (i_pipe_Reg2Data),
        .i_ack       (i_dmem_ack),
        .o_req       (o_dmem_req),
        .o_we        (o_dmem_we),
        .o_addr      (o_dmem_addr),
        .o_wdata     (o_dmem_wdata),
        .o_stall     (o_pipe_stall),
        .o_done      (fsm_done),
        .o_pass      (fsm_pass),
        .o_err       (o_dmem_err),
        .o_misaligned(o_misaligned)
    );

    // Anything other than a pass-through or a completed access writes an all-zero bubble.
    // EX/MEM is held while stalled, so the live inputs still describe the access on completion.
    always_comb begin
        mem_data_d   = '0;
        alu_result_d = '0;
        reg_dst_d    = '0;
        mem_to_reg_d = 1'b0;
        reg_wr_en_d  = 1'b0;
        if (fsm_pass || fsm_done) begin
            alu_result_d = i_pipe_AluResult;
            reg_dst_d    = i_pipe_RegDst;
            mem_to_reg_d = i_pipe_MemToReg;
            reg_wr_en_d  = i_pipe_RegWrEn;
            mem_data_d   = fsm_done ? i_dmem_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_data_q   <= '0;
            alu_result_q <= '0;
            reg_dst_q    <= '0;
            mem_to_reg_q <= 1'b0;
            reg_wr_en_q  <= 1'b0;
        end else begin
            mem_data_q   <= mem_data_d;
            alu_result_q <= alu_result_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_wr_en_q  <= reg_wr_en_d;
        end
    end

    assign o_pipe_MemData   = mem_data_q;
    assign o_pipe_AluResult = alu_result_q;
    assign o_pipe_RegDst    = reg_dst_q;
    assign o_pipe_MemToReg  = mem_to_reg_q;
    assign o_pipe_RegWrEn   = reg_wr_en_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected MEM/WB writes are queued when an
// instruction is driven and popped when the stage writes MEM/WB.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [31:0] i_pipe_TargetAddr;
    logic [31:0] i_pipe_AluResult;
    logic        i_pipe_Zero;
    logic [31:0] i_pipe_Reg2Data;
    logic [4:0]  i_pipe_RegDst;
    logic        i_pipe_MemToReg;
    logic        i_pipe_RegWrEn;
    logic        i_pipe_MemWrEn;
    logic        i_pipe_Branch;
    logic        i_pipe_Jump;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_pipe_stall;
    logic        o_PCSrc;
    logic [31:0] o_TargetAddr;
    logic [31:0] o_pipe_MemData;
    logic [31:0] o_pipe_AluResult;
    logic [4:0]  o_pipe_RegDst;
    logic        o_pipe_MemToReg;
    logic        o_pipe_RegWrEn;
    logic        o_dmem_err;
    logic        o_misaligned;

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic        m2r;
        logic        rwe;
    } wb_t;

    wb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    memory_stage #(.DMEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_pipe_TargetAddr(i_pipe_TargetAddr),
        .i_pipe_AluResult (i_pipe_AluResult),
        .i_pipe_Zero      (i_pipe_Zero),
        .i_pipe_Reg2Data  (i_pipe_Reg2Data),
        .i_pipe_RegDst    (i_pipe_RegDst),
        .i_pipe_MemToReg  (i_pipe_MemToReg),
        .i_pipe_RegWrEn   (i_pipe_RegWrEn),
        .i_pipe_MemWrEn   (i_pipe_MemWrEn),
        .i_pipe_Branch    (i_pipe_Branch),
        .i_pipe_Jump      (i_pipe_Jump),
        .o_dmem_req       (o_dmem_req),
        .o_dmem_we        (o_dmem_we),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_wdata     (o_dmem_wdata),
        .i_dmem_ack       (i_dmem_ack),
        .i_dmem_rdata     (i_dmem_rdata),
        .o_pipe_stall     (o_pipe_stall),
        .o_PCSrc          (o_PCSrc),
        .o_TargetAddr     (o_TargetAddr),
        .o_pipe_MemData   (o_pipe_MemData),
        .o_pipe_AluResult (o_pipe_AluResult),
        .o_pipe_RegDst    (o_pipe_RegDst),
        .o_pipe_MemToReg  (o_pipe_MemToReg),
        .o_pipe_RegWrEn   (o_pipe_RegWrEn),
        .o_dmem_err       (o_dmem_err),
        .o_misaligned     (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_wb(input logic [31:0] mem_data, input logic [31:0] alu,
                           input logic [4:0] dst, input logic m2r, input logic rwe);
        wb_t e;
        e.mem_data = mem_data;
        e.alu      = alu;
        e.dst      = dst;
        e.m2r      = m2r;
        e.rwe      = rwe;
        sb.push_back(e);
    endtask

    task automatic push_bubble();
        push_wb(32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic pop_wb(input string tag);
        wb_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb_empty: observed %0d entries expected >0", tag, sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_memdata"}, o_pipe_MemData, e.mem_data);
            chk({tag, "_alu"}, o_pipe_AluResult, e.alu);
            chk({tag, "_regdst"}, 32'(o_pipe_RegDst), 32'(e.dst));
            chk({tag, "_memtoreg"}, 32'(o_pipe_MemToReg), 32'(e.m2r));
            chk({tag, "_regwren"}, 32'(o_pipe_RegWrEn), 32'(e.rwe));
        end
    endtask

    task automatic drive_bubble();
        i_pipe_TargetAddr = 32'd0;
        i_pipe_AluResult  = 32'd0;
        i_pipe_Zero       = 1'b0;
        i_pipe_Reg2Data   = 32'd0;
        i_pipe_RegDst     = 5'd0;
        i_pipe_MemToReg   = 1'b0;
        i_pipe_RegWrEn    = 1'b0;
        i_pipe_MemWrEn    = 1'b0;
        i_pipe_Branch     = 1'b0;
        i_pipe_Jump       = 1'b0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [4:0] dst);
        drive_bubble();
        i_pipe_AluResult = addr;
        i_pipe_RegDst    = dst;
        i_pipe_MemToReg  = 1'b1;
        i_pipe_RegWrEn   = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'd0;
        drive_bubble();
        i_pipe_MemToReg = 1'b1;

        // Reset state, with a load presented on the inputs
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(o_pipe_stall), 32'd0);
        chk("rst_req", 32'(o_dmem_req), 32'd0);
        chk("rst_addr", o_dmem_addr, 32'd0);
        chk("rst_regwren", 32'(o_pipe_RegWrEn), 32'd0);
        chk("rst_memdata", o_pipe_MemData, 32'd0);
        chk("rst_err", 32'(o_dmem_err), 32'd0);
        chk("rst_misal", 32'(o_misaligned), 32'd0);
        drive_bubble();
        reset = 1'b0;
        tick();

        // Non-memory pass-through
        drive_bubble();
        i_pipe_AluResult = 32'h0000_1234;
        i_pipe_RegDst    = 5'd5;
        i_pipe_RegWrEn   = 1'b1;
        #1;
        chk("pass_stall", 32'(o_pipe_stall), 32'd0);
        push_wb(32'd0, 32'h0000_1234, 5'd5, 1'b0, 1'b1);
        tick();
        chk("pass_stall_after", 32'(o_pipe_stall), 32'd0);
        pop_wb("pass");
        drive_bubble();

        // Load 0x100, ack in the 3rd WAIT cycle
        drive_load(32'h0000_0100, 5'd7);
        #1;
        chk("ld_stall_c0", 32'(o_pipe_stall), 32'd1);
        chk("ld_req_c0", 32'(o_dmem_req), 32'd0);
        push_bubble();
        tick();
        chk("ld_req_w1", 32'(o_dmem_req), 32'd1);
        chk("ld_addr_w1", o_dmem_addr, 32'h0000_0100);
        chk("ld_we_w1", 32'(o_dmem_we), 32'd0);
        chk("ld_stall_w1", 32'(o_pipe_stall), 32'd1);
        pop_wb("ld_bub1");
        push_bubble();
        tick();
        chk("ld_req_w2", 32'(o_dmem_req), 32'd1);
        chk("ld_addr_w2", o_dmem_addr, 32'h0000_0100);
        chk("ld_stall_w2", 32'(o_pipe_stall), 32'd1);
        pop_wb("ld_bub2");
        push_bubble();
        tick();
        chk("ld_req_w3", 32'(o_dmem_req), 32'd1);
        pop_wb("ld_bub3");
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("ld_stall_ack", 32'(o_pipe_stall), 32'd0);
        push_wb(32'hDEAD_BEEF, 32'h0000_0100, 5'd7, 1'b1, 1'b1);
        tick();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'd0;
        drive_bubble();
        chk("ld_req_done", 32'(o_dmem_req), 32'd0);
        pop_wb("ld_wb");

        // Store 0x200 with immediate ack
        drive_bubble();
        i_pipe_AluResult = 32'h0000_0200;
        i_pipe_Reg2Data  = 32'hA5A5_A5A5;
        i_pipe_MemWrEn   = 1'b1;
        #1;
        chk("st_stall_c0", 32'(o_pipe_stall), 32'd1);
        tick();
        chk("st_req", 32'(o_dmem_req), 32'd1);
        chk("st_we", 32'(o_dmem_we), 32'd1);
        chk("st_addr", o_dmem_addr, 32'h0000_0200);
        chk("st_wdata", o_dmem_wdata, 32'hA5A5_A5A5);
        i_dmem_ack = 1'b1;
        #1;
        chk("st_stall_ack", 32'(o_pipe_stall), 32'd0);
        push_wb(32'd0, 32'h0000_0200, 5'd0, 1'b0, 1'b0);
        tick();
        i_dmem_ack = 1'b0;
        drive_bubble();
        chk("st_req_done", 32'(o_dmem_req), 32'd0);
        pop_wb("st_wb");

        // Load with no ack: abandoned after 4 WAIT cycles
        drive_load(32'h0000_0300, 5'd9);
        #1;
        chk("to_stall_c0", 32'(o_pipe_stall), 32'd1);
        tick();
        for (int w = 1; w <= 3; w++) begin
            chk($sformatf("to_req_w%0d", w), 32'(o_dmem_req), 32'd1);
            chk($sformatf("to_stall_w%0d", w), 32'(o_pipe_stall), 32'd1);
            chk($sformatf("to_err_w%0d", w), 32'(o_dmem_err), 32'd0);
            tick();
        end
        chk("to_req_w4", 32'(o_dmem_req), 32'd1);
        chk("to_stall_w4", 32'(o_pipe_stall), 32'd0);
        push_bubble();
        tick();
        drive_bubble();
        chk("to_err_pulse", 32'(o_dmem_err), 32'd1);
        chk("to_req_drop", 32'(o_dmem_req), 32'd0);
        pop_wb("to_wb");
        tick();
        chk("to_err_clear", 32'(o_dmem_err), 32'd0);
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h1234_5678;
        #1;
        chk("late_ack_stall", 32'(o_pipe_stall), 32'd0);
        tick();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'd0;
        chk("late_ack_req", 32'(o_dmem_req), 32'd0);
        chk("late_ack_memdata", o_pipe_MemData, 32'd0);
        chk("late_ack_regwren", 32'(o_pipe_RegWrEn), 32'd0);
        chk("late_ack_err", 32'(o_dmem_err), 32'd0);

        // Misaligned load plus taken branch
        drive_load(32'h0000_0102, 5'd3);
        i_pipe_Branch     = 1'b1;
        i_pipe_Zero       = 1'b1;
        i_pipe_TargetAddr = 32'hCAFE_0010;
        #1;
        chk("mis_stall", 32'(o_pipe_stall), 32'd0);
        chk("br_pcsrc", 32'(o_PCSrc), 32'd1);
        chk("br_target", o_TargetAddr, 32'hCAFE_0010);
        push_bubble();
        tick();
        chk("mis_pulse", 32'(o_misaligned), 32'd1);
        chk("mis_req", 32'(o_dmem_req), 32'd0);
        pop_wb("mis_wb");
        drive_bubble();
        i_pipe_Branch = 1'b1;
        #1;
        chk("br_nottaken", 32'(o_PCSrc), 32'd0);
        i_pipe_Branch = 1'b0;
        i_pipe_Jump   = 1'b1;
        #1;
        chk("jmp_pcsrc", 32'(o_PCSrc), 32'd1);
        drive_bubble();
        tick();
        chk("mis_clear", 32'(o_misaligned), 32'd0);

        // Reset asserted in the 2nd WAIT cycle
        drive_load(32'h0000_0400, 5'd4);
        tick();
        chk("rw_req_w1", 32'(o_dmem_req), 32'd1);
        tick();
        chk("rw_req_w2", 32'(o_dmem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rw_req", 32'(o_dmem_req), 32'd0);
        chk("rw_stall", 32'(o_pipe_stall), 32'd0);
        chk("rw_addr", o_dmem_addr, 32'd0);
        chk("rw_regwren", 32'(o_pipe_RegWrEn), 32'd0);
        drive_bubble();
        tick();
        reset = 1'b0;
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'h5555_AAAA;
        #1;
        chk("rw_ack_stall", 32'(o_pipe_stall), 32'd0);
        tick();
        i_dmem_ack   = 1'b0;
        i_dmem_rdata = 32'd0;
        chk("rw_ack_req", 32'(o_dmem_req), 32'd0);
        chk("rw_ack_memdata", o_pipe_MemData, 32'd0);
        // Back in IDLE: a plain op passes straight through
        i_pipe_AluResult = 32'h0000_0ABC;
        i_pipe_RegDst    = 5'd11;
        i_pipe_RegWrEn   = 1'b1;
        push_wb(32'd0, 32'h0000_0ABC, 5'd11, 1'b0, 1'b1);
        tick();
        pop_wb("rw_idle");
        drive_bubble();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
